// File: rtl/fdu_pkg.sv
// Shared constants for the multi-channel fault-detection unit: prime FSM encoding,
// default parameter values and the lowest-set-bit picker used for prime selection.
package fdu_pkg;

  localparam logic [1:0] ST_INIT   = 2'b00;
  localparam logic [1:0] ST_ACTIVE = 2'b01;
  localparam logic [1:0] ST_NONE   = 2'b10;

  localparam int DEF_N_CH      = 4;
  localparam int DEF_HB_W      = 3;
  localparam int DEF_WD_LIMIT  = 1000000;
  localparam int DEF_RECOVER_N = 4;
  localparam int DEF_POR_LEN   = 50000000;
  localparam int DEF_TIMEOUT   = 250000000;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Lowest-index set bit of a channel vector (up to 8 channels).
  function automatic pick_t lowest_set(input logic [7:0] vec);
    pick_t res;
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        res.found = 1'b1;
        res.idx   = 3'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hb_monitor.sv
// One heartbeat channel: input synchroniser, activity detection, watchdog,
// recovery counting and the power-on-reset pulse issued after a health loss.
module hb_monitor
  import fdu_pkg::*;
#(
  parameter int HB_W      = DEF_HB_W,
  parameter int WD_LIMIT  = DEF_WD_LIMIT,
  parameter int RECOVER_N = DEF_RECOVER_N,
  parameter int POR_LEN   = DEF_POR_LEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [HB_W-1:0] hb,
  input  logic            error,
  output logic            health,
  output logic            por
);

  localparam int WD_W  = $clog2(WD_LIMIT + 1);
  localparam int REC_W = $clog2(RECOVER_N + 1);
  localparam int POR_W = $clog2(POR_LEN + 1);

  logic [HB_W-1:0]  sync1_r, sync2_r, prev_r;
  logic [WD_W-1:0]  wd_cnt_r;
  logic [REC_W-1:0] rec_cnt_r;
  logic [REC_W-1:0] rec_base_s;
  logic [POR_W-1:0] por_cnt_r;
  logic             health_r, health_d_r, por_r;
  logic             activity_s, wd_expired_s;

  assign activity_s   = (sync2_r != prev_r) && !error;
  assign wd_expired_s = (wd_cnt_r == WD_W'(WD_LIMIT));
  // A gap that let the watchdog expire restarts the recovery sequence.
  assign rec_base_s   = wd_expired_s ? {REC_W{1'b0}} : rec_cnt_r;

  // Two-flop synchroniser plus previous sample for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= {HB_W{1'b0}};
      sync2_r <= {HB_W{1'b0}};
      prev_r  <= {HB_W{1'b0}};
    end else begin
      sync1_r <= hb;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Watchdog, recovery counter and health flag; all frozen while por is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_r   <= {WD_W{1'b0}};
      rec_cnt_r  <= {REC_W{1'b0}};
      health_r   <= 1'b0;
      health_d_r <= 1'b0;
    end else begin
      health_d_r <= health_r;
      if (por_r) begin
        wd_cnt_r  <= {WD_W{1'b0}};
        rec_cnt_r <= {REC_W{1'b0}};
        health_r  <= 1'b0;
      end else begin
        if (activity_s) begin
          wd_cnt_r <= {WD_W{1'b0}};
        end else if (!wd_expired_s) begin
          wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
          wd_cnt_r <= wd_cnt_r;
        end
        if (health_r) begin
          rec_cnt_r <= {REC_W{1'b0}};
          health_r  <= !wd_expired_s;
        end else if (activity_s) begin
          if (rec_base_s == REC_W'(RECOVER_N - 1)) begin
            rec_cnt_r <= {REC_W{1'b0}};
            health_r  <= 1'b1;
          end else begin
            rec_cnt_r <= rec_base_s + REC_W'(1);
            health_r  <= 1'b0;
          end
        end else begin
          rec_cnt_r <= rec_base_s;
          health_r  <= 1'b0;
        end
      end
    end
  end

  // Por pulse of POR_LEN cycles, launched the cycle after health drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      por_r     <= 1'b0;
      por_cnt_r <= {POR_W{1'b0}};
    end else if (por_r) begin
      if (por_cnt_r == {POR_W{1'b0}}) begin
        por_r <= 1'b0;
      end else begin
        por_cnt_r <= por_cnt_r - POR_W'(1);
      end
    end else if (health_d_r && !health_r) begin
      por_r     <= 1'b1;
      por_cnt_r <= POR_W'(POR_LEN - 1);
    end else begin
      por_r     <= 1'b0;
      por_cnt_r <= por_cnt_r;
    end
  end

  assign health = health_r;
  assign por    = por_r;

endmodule

// File: rtl/fdu_nchan.sv
// N-channel fault-detection unit: per-channel heartbeat monitors feeding a prime
// selector that keeps one healthy channel marked as prime and counts switches.
module fdu_nchan
  import fdu_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int HB_W      = DEF_HB_W,
  parameter int WD_LIMIT  = DEF_WD_LIMIT,
  parameter int RECOVER_N = DEF_RECOVER_N,
  parameter int POR_LEN   = DEF_POR_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH*HB_W-1:0]    hb,
  input  logic [N_CH-1:0]         error,
  output logic [N_CH-1:0]         health,
  output logic [N_CH-1:0]         por,
  output logic [N_CH-1:0]         prime,
  output logic                    prime_valid,
  output logic [$clog2(N_CH)-1:0] prime_idx,
  output logic [15:0]             switch_cnt
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic [N_CH-1:0]  health_bus;
  logic [7:0]       health_ext_s, others_s;
  pick_t            any_pick_s, other_pick_s;
  logic [TO_W-1:0]  to_cnt_r;
  logic             to_reached_r;
  logic [1:0]       state_r, state_nx;
  logic             valid_r, valid_nx;
  logic [IDX_W-1:0] idx_r, idx_nx;
  logic [N_CH-1:0]  prime_r, prime_nx;
  logic [15:0]      switch_cnt_r;

  for (genvar g = 0; g < N_CH; g++) begin : g_mon
    hb_monitor #(
      .HB_W      (HB_W),
      .WD_LIMIT  (WD_LIMIT),
      .RECOVER_N (RECOVER_N),
      .POR_LEN   (POR_LEN)
    ) u_mon (
      .clk    (clk),
      .reset  (reset),
      .hb     (hb[g*HB_W +: HB_W]),
      .error  (error[g]),
      .health (health_bus[g]),
      .por    (por[g])
    );
  end

  assign health_ext_s = 8'(health_bus);
  assign others_s     = health_ext_s & ~(8'd1 << idx_r);
  assign any_pick_s   = lowest_set(health_ext_s);
  assign other_pick_s = lowest_set(others_s);

  // Startup window; only channel 0 may claim prime until it expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_r     <= {TO_W{1'b0}};
      to_reached_r <= 1'b0;
    end else if (!to_reached_r) begin
      if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
        to_reached_r <= 1'b1;
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end else begin
      to_reached_r <= 1'b1;
    end
  end

  // Prime selection; an established prime is never preempted while healthy.
  always_comb begin
    state_nx = state_r;
    valid_nx = valid_r;
    idx_nx   = idx_r;
    case (state_r)
      ST_INIT: begin
        if (health_bus[0]) begin
          state_nx = ST_ACTIVE;
          valid_nx = 1'b1;
          idx_nx   = {IDX_W{1'b0}};
        end else if (to_reached_r && any_pick_s.found) begin
          state_nx = ST_ACTIVE;
          valid_nx = 1'b1;
          idx_nx   = IDX_W'(any_pick_s.idx);
        end else begin
          state_nx = ST_INIT;
        end
      end
      ST_ACTIVE: begin
        if (health_bus[idx_r]) begin
          state_nx = ST_ACTIVE;
        end else if (other_pick_s.found) begin
          idx_nx = IDX_W'(other_pick_s.idx);
        end else begin
          state_nx = ST_NONE;
          valid_nx = 1'b0;
          idx_nx   = {IDX_W{1'b0}};
        end
      end
      ST_NONE: begin
        if (any_pick_s.found) begin
          state_nx = ST_ACTIVE;
          valid_nx = 1'b1;
          idx_nx   = IDX_W'(any_pick_s.idx);
        end else begin
          state_nx = ST_NONE;
        end
      end
      default: begin
        state_nx = ST_INIT;
        valid_nx = 1'b0;
        idx_nx   = {IDX_W{1'b0}};
      end
    endcase
  end

  // One-hot prime vector derived from the next selection.
  always_comb begin
    prime_nx = {N_CH{1'b0}};
    if (valid_nx) begin
      prime_nx = N_CH'(1'b1) << idx_nx;
    end else begin
      prime_nx = {N_CH{1'b0}};
    end
  end

  // Registered prime outputs and saturating switch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_INIT;
      valid_r      <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
      prime_r      <= {N_CH{1'b0}};
      switch_cnt_r <= 16'h0000;
    end else begin
      state_r <= state_nx;
      valid_r <= valid_nx;
      idx_r   <= idx_nx;
      prime_r <= prime_nx;
      if ((prime_nx != prime_r) && (switch_cnt_r != 16'hFFFF)) begin
        switch_cnt_r <= switch_cnt_r + 16'd1;
      end else begin
        switch_cnt_r <= switch_cnt_r;
      end
    end
  end

  assign health      = health_bus;
  assign prime       = prime_r;
  assign prime_valid = valid_r;
  assign prime_idx   = idx_r;
  assign switch_cnt  = switch_cnt_r;

endmodule

// File: tb/tb_fdu_nchan.sv
// Directed bench for fdu_nchan: linear scenarios with a queue of expected values
// that is filled as each step is driven and drained at each comparison point.
module tb_fdu_nchan;

  localparam int N_CH = 4;
  localparam int HB_W = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_CH*HB_W-1:0] hb;
  logic [N_CH-1:0]      error;
  logic [N_CH-1:0]      health, por, prime;
  logic                 prime_valid;
  logic [1:0]           prime_idx;
  logic [15:0]          switch_cnt;

  logic [31:0]     exp_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;
  logic [N_CH-1:0] tog_en;
  int              last_tog[N_CH];
  int              ntog[N_CH];
  int              plen;

  fdu_nchan #(
    .N_CH(4), .HB_W(3), .WD_LIMIT(16), .RECOVER_N(3), .POR_LEN(8), .TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .hb(hb), .error(error), .health(health), .por(por),
    .prime(prime), .prime_valid(prime_valid), .prime_idx(prime_idx), .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  // one clock; inputs change and outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_CH; i++) begin
      if (tog_en[i] && (cyc % 4 == 0)) begin
        hb[i*HB_W +: HB_W] = hb[i*HB_W +: HB_W] + 3'd1;
        last_tog[i] = cyc;
        ntog[i]++;
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push_exp(e);
    check(tag, obs);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < N_CH; i++) begin
      ntog[i]     = 0;
      last_tog[i] = 0;
    end
  endtask

  task automatic apply_reset();
    hb     = '0;
    error  = '0;
    tog_en = '0;
    reset  = 1'b1;
    step();
    step();
    release_reset();
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_health"}, health, 0);
    cmp({tag, "_por"}, por, 0);
    cmp({tag, "_prime"}, prime, 0);
    cmp({tag, "_valid"}, prime_valid, 0);
    cmp({tag, "_idx"}, prime_idx, 0);
    cmp({tag, "_swcnt"}, switch_cnt, 0);
  endtask

  initial begin
    reset  = 1'b1;
    hb     = '0;
    error  = '0;
    tog_en = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");

    // ch0 alone: healthy on its third event, prime one cycle later
    release_reset();
    tog_en = 4'b0001;
    for (int k = 0; k < 40 && !health[0]; k++) step();
    cmp("a_health0", health[0], 1);
    cmp("a_events", ntog[0], 3);
    cmp("a_prime_lat", prime, 4'b0000);
    step();
    cmp("a_prime", prime, 4'b0001);
    cmp("a_idx", prime_idx, 0);
    cmp("a_valid", prime_valid, 1);
    cmp("a_swcnt", switch_cnt, 1);

    // ch2 alone: no prime until the startup window expires
    apply_reset();
    tog_en = 4'b0100;
    while (cyc < 99) step();
    cmp("b_health2", health[2], 1);
    cmp("b_prime_pre", prime, 4'b0000);
    while (cyc < 102) step();
    cmp("b_prime", prime, 4'b0100);
    cmp("b_idx", prime_idx, 2);
    cmp("b_swcnt", switch_cnt, 1);

    // ch0 prime with ch1/ch3 healthy; ch0 goes quiet
    apply_reset();
    tog_en = 4'b1011;
    for (int k = 0; k < 40 && health != 4'b1011; k++) step();
    cmp("c_healthy", health, 4'b1011);
    step();
    cmp("c_prime0", prime, 4'b0001);
    tog_en[0] = 1'b0;
    for (int k = 0; k < 60 && health[0]; k++) step();
    cmp("c_h0_fall", health[0], 0);
    cmp("c_quiet", cyc - last_tog[0], 20);
    cmp("c_prime_hold", prime, 4'b0001);
    cmp("c_por_pre", por[0], 0);
    step();
    cmp("c_prime1", prime, 4'b0010);
    cmp("c_idx", prime_idx, 1);
    cmp("c_swcnt", switch_cnt, 2);
    plen = 0;
    for (int k = 0; k < 20 && por[0]; k++) begin
      plen++;
      step();
    end
    cmp("c_por_len", plen, 8);
    cmp("c_h0_after_por", health[0], 0);

    // ch1 sole prime, masked by error, then recovers
    apply_reset();
    tog_en = 4'b0010;
    while (cyc < 104) step();
    cmp("d_prime1", prime, 4'b0010);
    error[1] = 1'b1;
    for (int k = 0; k < 40 && health[1]; k++) step();
    cmp("d_h1_fall", health[1], 0);
    step();
    cmp("d_prime_none", prime, 4'b0000);
    cmp("d_valid", prime_valid, 0);
    cmp("d_idx", prime_idx, 0);
    cmp("d_swcnt_none", switch_cnt, 2);
    error[1] = 1'b0;
    for (int k = 0; k < 80 && !health[1]; k++) step();
    cmp("d_h1_up", health[1], 1);
    cmp("d_prime_lat", prime, 4'b0000);
    step();
    cmp("d_prime_back", prime, 4'b0010);
    cmp("d_swcnt_back", switch_cnt, 3);

    // reset in the middle of a por[2] pulse
    apply_reset();
    tog_en = 4'b0101;
    for (int k = 0; k < 40 && health != 4'b0101; k++) step();
    step();
    cmp("e_prime0", prime, 4'b0001);
    tog_en[2] = 1'b0;
    for (int k = 0; k < 60 && !por[2]; k++) step();
    cmp("e_por2", por[2], 1);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("e_mid");
    hb     = '0;
    tog_en = '0;
    step();
    step();
    release_reset();
    tog_en = 4'b0100;
    while (cyc < 40) step();
    cmp("e_h2", health[2], 1);
    cmp("e_init", prime, 4'b0000);

    // alternate forced health to switch prime every cycle
    apply_reset();
    for (int k = 1; k <= 65540; k++) begin
      if (k % 2 == 1) force dut.health_bus = 4'b0001;
      else            force dut.health_bus = 4'b0010;
      step();
      if (k == 65534) cmp("f_swcnt_fffe", switch_cnt, 16'hFFFE);
    end
    cmp("f_swcnt_sat", switch_cnt, 16'hFFFF);
    cmp("f_prime", prime, 4'b0010);
    release dut.health_bus;
    step();
    step();
    cmp("f_sat_hold", switch_cnt, 16'hFFFF);
    cmp("f_none", prime_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
